// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter: the PPU fetch port has priority, and the CPU port
// gets a forced slot once it has lost STARVE_MAX consecutive cycles.
module vram_arbiter #(
    parameter int AW         = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ppu_req,
    input  logic [AW-1:0] ppu_addr,
    output logic          ppu_gnt,
    output logic          ppu_rvalid,
    output logic [7:0]    ppu_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    output logic          mem_ce,
    output logic          mem_oce,
    output logic          mem_wre,
    output logic [AW-1:0] mem_ad,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic [1:0] rd_owner_q, rd_owner_d;   // [1] = PPU, [0] = CPU
    logic       ppu_sel, cpu_sel;

    always_comb begin
        cpu_sel = resetn && cpu_req && (!ppu_req || (starve_q == STARVE_LIM));
        ppu_sel = resetn && ppu_req && !cpu_sel;
    end

    always_comb begin
        starve_d = starve_q;
        if (!cpu_req || cpu_sel) begin
            starve_d = '0;
        end else if (ppu_sel && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
        rd_owner_d = {ppu_sel, cpu_sel && !cpu_we};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_q   <= '0;
            rd_owner_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ppu_gnt = ppu_sel;
    assign cpu_ack = cpu_sel;

    assign mem_ce  = ppu_sel | cpu_sel;
    assign mem_oce = 1'b1;
    assign mem_wre = cpu_sel && cpu_we;
    assign mem_ad  = cpu_sel ? cpu_addr : (ppu_sel ? ppu_addr : '0);
    assign mem_din = cpu_sel ? cpu_wdata : '0;

    // Read data returns one cycle after issue; route it to whoever issued it.
    assign ppu_rvalid = rd_owner_q[1];
    assign cpu_rvalid = rd_owner_q[0];
    assign ppu_rdata  = ppu_rvalid ? mem_dout : '0;
    assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural VRAM, directed sequences and a random
// contention phase, with read returns checked by a scoreboard monitor.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ppu_req, cpu_req, cpu_we;
    logic [AW-1:0] ppu_addr, cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          ppu_gnt, ppu_rvalid, cpu_ack, cpu_rvalid;
    logic [7:0]    ppu_rdata, cpu_rdata;
    logic          mem_ce, mem_oce, mem_wre;
    logic [AW-1:0] mem_ad;
    logic [7:0]    mem_din, mem_dout;

    vram_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .resetn(resetn),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt),
        .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // VRAM macro model and the bench's own reference copy of its contents.
    logic [7:0] vram    [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) vram[mem_ad] <= mem_din;
            else         mem_dout     <= vram[mem_ad];
        end
    end

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7 + 3) ^ (a >> 8));
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         stamp;
    } rd_t;
    rd_t pq[$];
    rd_t cq[$];

    int mon_chk = 0, mon_fail = 0;
    int main_chk = 0, main_fail = 0;
    int wait_c = 0;

    // Monitor: retire returns first, then log this cycle's issues.
    always @(negedge clk) begin
        if (pq.size() > 0 && pq[0].stamp == cyc - 1) begin
            mon_chk++;
            if (ppu_rvalid !== 1'b1 || ppu_rdata !== pq[0].d) begin
                mon_fail++;
                $display("FAIL ppu_return cyc=%0d: rvalid=%b data=%02h, required rvalid=1 data=%02h",
                         cyc, ppu_rvalid, ppu_rdata, pq[0].d);
            end
            void'(pq.pop_front());
        end else if (ppu_rvalid === 1'b1) begin
            mon_chk++; mon_fail++;
            $display("FAIL ppu_spurious_rvalid cyc=%0d: rvalid=1, required 0", cyc);
        end
        if (cq.size() > 0 && cq[0].stamp == cyc - 1) begin
            mon_chk++;
            if (cpu_rvalid !== 1'b1 || cpu_rdata !== cq[0].d) begin
                mon_fail++;
                $display("FAIL cpu_return cyc=%0d: rvalid=%b data=%02h, required rvalid=1 data=%02h",
                         cyc, cpu_rvalid, cpu_rdata, cq[0].d);
            end
            void'(cq.pop_front());
        end else if (cpu_rvalid === 1'b1) begin
            mon_chk++; mon_fail++;
            $display("FAIL cpu_spurious_rvalid cyc=%0d: rvalid=1, required 0", cyc);
        end
        if (ppu_gnt === 1'b1 && cpu_ack === 1'b1) begin
            mon_fail++;
            $display("FAIL grant_exclusive cyc=%0d: ppu_gnt=1 cpu_ack=1, required at most one", cyc);
        end
        if (resetn === 1'b0) begin
            mon_chk++;
            if (mem_wre !== 1'b0 || mem_ce !== 1'b0) begin
                mon_fail++;
                $display("FAIL reset_mem_quiet cyc=%0d: ce=%b wre=%b, required 0 0", cyc, mem_ce, mem_wre);
            end
        end
        if (cpu_ack === 1'b1) begin
            mon_chk++;
            if (wait_c > SMAX) begin
                mon_fail++;
                $display("FAIL cpu_wait cyc=%0d: waited %0d, required <= %0d", cyc, wait_c, SMAX);
            end
            wait_c = 0;
        end else if (resetn === 1'b1 && cpu_req === 1'b1) begin
            wait_c++;
        end else begin
            wait_c = 0;
        end
        if (ppu_gnt === 1'b1) pq.push_back('{ref_mem[ppu_addr], cyc});
        if (cpu_ack === 1'b1) begin
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else        cq.push_back('{ref_mem[cpu_addr], cyc});
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        main_chk++;
        if (got !== exp) begin
            main_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold PPU requests and raise one CPU access; expect SMAX PPU wins, then the ack.
    task automatic starve_round(input logic we, input logic [7:0] wd, input int base);
        ppu_req   = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = 15'h0123;
        cpu_wdata = wd;
        for (int k = 0; k < SMAX; k++) begin
            ppu_addr = 15'(base + k);
            @(negedge clk);
            chk($sformatf("starve_ppu_win_%0d", k), {ppu_gnt, cpu_ack}, 2'b10);
            tick();
        end
        ppu_addr = 15'(base + SMAX);
        @(negedge clk);
        chk("starve_cpu_forced", {ppu_gnt, cpu_ack}, 2'b01);
        chk("starve_mem_ad", 32'(mem_ad), 32'h0123);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("starve_ppu_resume", {ppu_gnt, cpu_ack}, 2'b10);
        tick();
    endtask

    initial begin
        int  gcount;
        logic ack;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        resetn = 1'b0; ppu_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        ppu_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        tick();

        // Reset with both requesters active.
        ppu_req = 1'b1; ppu_addr = 15'h0010;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h4001; cpu_wdata = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_grants", {ppu_gnt, cpu_ack, mem_ce, mem_wre}, 4'b0000);
            chk("reset_oce", 32'(mem_oce), 1);
            chk("reset_rvalid", {ppu_rvalid, cpu_rvalid, ppu_rdata, cpu_rdata}, '0);
            tick();
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_ppu_first", {ppu_gnt, cpu_ack}, 2'b10);
        tick();

        // CPU write then read-back of 0x4001 with the PPU idle.
        ppu_req = 1'b0;
        @(negedge clk);
        chk("cpu_write_issue", {cpu_ack, mem_wre, ppu_gnt}, 3'b110);
        chk("cpu_write_ad", 32'(mem_ad), 32'h4001);
        chk("cpu_write_din", 32'(mem_din), 32'h5A);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("cpu_read_issue", {cpu_ack, mem_wre}, 2'b10);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_read_data", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h5A});
        tick();

        // PPU stream 0x00..0xFF.
        gcount = 0;
        for (int a = 0; a < 256; a++) begin
            ppu_req  = 1'b1;
            ppu_addr = 15'(a);
            @(negedge clk);
            if (ppu_gnt === 1'b1) gcount++;
            tick();
        end
        ppu_req = 1'b0;
        chk("stream_grants", 32'(gcount), 256);
        @(negedge clk);
        tick();

        // Starvation: two rounds show the counter clears after each forced slot.
        starve_round(1'b0, 8'h00, 16'h0200);
        starve_round(1'b1, 8'h77, 16'h0300);
        ppu_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0123;
        @(negedge clk);
        chk("starve_write_seen_issue", 32'(cpu_ack), 1);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("starve_write_seen_data", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h77});
        tick();

        // Reset in the cycle after a PPU read, with a CPU write pending.
        ppu_req = 1'b1; ppu_addr = 15'h0042;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0042; cpu_wdata = 8'hEE;
        @(negedge clk);
        chk("midrst_issue", {ppu_gnt, cpu_ack}, 2'b10);
        tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid_kept", {ppu_rvalid, ppu_rdata}, {1'b1, pat(16'h0042)});
        chk("midrst_no_grant", {ppu_gnt, cpu_ack, mem_wre}, 3'b000);
        tick();
        @(negedge clk);
        chk("midrst_rvalid_cleared", 32'(ppu_rvalid), 0);
        tick();
        resetn = 1'b1; ppu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk("midrst_readback_issue", 32'(cpu_ack), 1);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("midrst_not_written", {cpu_rvalid, cpu_rdata}, {1'b1, pat(16'h0042)});
        tick();

        // Random contention over a small address window.
        for (int n = 0; n < 10000; n++) begin
            ppu_req  = ($urandom_range(0, 3) != 0);
            ppu_addr = 15'($urandom_range(0, 63));
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 15'($urandom_range(0, 63));
                cpu_wdata = 8'($urandom);
            end
            @(negedge clk);
            ack = cpu_ack;
            tick();
            if (ack) cpu_req = 1'b0;
        end
        ppu_req = 1'b0; cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        chk("queues_drained", 32'(pq.size() + cq.size()), 0);

        $display("%0d/%0d checks passed",
                 (main_chk + mon_chk) - (main_fail + mon_fail), main_chk + mon_chk);
        $finish;
    end

endmodule
